k10_ibus_axi: RTL and testbench

//  Instruction-bus to AXI4-Lite read-master adapter sitting directly upstream of the K10 fetch stage.

---
 rtl/komandara_k10_pkg.sv | 6 +
 rtl/k10_ibus_hitbuf.sv | 30 +++
 rtl/k10_ibus_axi.sv | 96 +++++++++
 tb/tb_k10_ibus_axi.sv | 109 ++++++++++
 4 files changed

// File: rtl/komandara_k10_pkg.sv
// komandara_k10_pkg: shared types and constants for the K10 instruction-bus AXI adapter.
package komandara_k10_pkg;
  typedef enum logic [1:0] {IBUS_IDLE, IBUS_AR_SEND, IBUS_R_WAIT, IBUS_DRAIN} ibus_axi_state_e;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] IBUS_ARPROT_DEF = 3'b100;
endpackage

// File: rtl/k10_ibus_hitbuf.sv
// k10_ibus_hitbuf: one-entry fetch hit buffer (last OKAY word), cleared by fence.i invalidate.
module k10_ibus_hitbuf (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookup,
  input  logic        inv,
  input  logic        fill,
  input  logic [29:0] fill_addr,
  input  logic [31:0] fill_data,
  output logic        hit,
  output logic [31:0] data
);
  logic        valid;
  logic [29:0] tag;
  // An invalidate in the lookup cycle forces a miss so stale code is never returned.
  assign hit = valid && tag == lookup && !inv;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else begin
      if (inv) valid <= 1'b0;
      else if (fill) valid <= 1'b1;
      if (fill) begin
        tag  <= fill_addr;
        data <= fill_data;
      end
    end
endmodule

// File: rtl/k10_ibus_axi.sv
// k10_ibus_axi: single-outstanding instruction-bus to AXI4-Lite read adapter.
// Optional one-entry hit buffer enabled by defining K10_IBUS_HITBUF_EN.
module k10_ibus_axi
  import komandara_k10_pkg::*;
#(
  parameter int          RESP_TIMEOUT = 0,
  parameter logic [2:0]  ARPROT_VAL   = IBUS_ARPROT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ibus_req,
  input  logic [31:0] i_ibus_addr,
  output logic        o_ibus_gnt,
  output logic        o_ibus_rvalid,
  output logic [31:0] o_ibus_rdata,
  output logic        o_ibus_err,
  input  logic        i_inv,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp
);
  localparam int CW = RESP_TIMEOUT > 1 ? $clog2(RESP_TIMEOUT) : 1;
  ibus_axi_state_e state;
  logic [29:0]     addr_q;
  logic [CW-1:0]   cnt;
  logic            hit, pend, r_ok, tmo, rwait;
  logic [31:0]     hb_data;
  logic            unused_lsb;
  assign unused_lsb = ^i_ibus_addr[1:0];
  assign rwait = state == IBUS_R_WAIT;
  assign r_ok  = rwait && m_axi_rvalid;
  // A beat arriving in the timeout cycle wins over the synthesised error.
  assign tmo   = RESP_TIMEOUT > 0 && rwait && !m_axi_rvalid && int'(cnt) == RESP_TIMEOUT - 1;
`ifdef K10_IBUS_HITBUF_EN
  k10_ibus_hitbuf u_hitbuf (
    .clk       (i_clk),
    .rst       (i_rst),
    .lookup    (i_ibus_addr[31:2]),
    .inv       (i_inv),
    .fill      (r_ok && m_axi_rresp == AXI_RESP_OKAY),
    .fill_addr (addr_q),
    .fill_data (m_axi_rdata),
    .hit       (hit),
    .data      (hb_data)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) pend <= 1'b0;
    else pend <= o_ibus_gnt && hit;
`else
  logic unused_inv;
  assign unused_inv = i_inv;
  assign hit        = 1'b0;
  assign pend       = 1'b0;
  assign hb_data    = '0;
`endif
  assign o_ibus_gnt = state == IBUS_IDLE && i_ibus_req && !pend;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state  <= IBUS_IDLE;
      addr_q <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IBUS_IDLE:
          if (o_ibus_gnt && !hit) begin
            addr_q <= i_ibus_addr[31:2];
            state  <= IBUS_AR_SEND;
          end
        IBUS_AR_SEND:
          if (m_axi_arready) begin
            state <= IBUS_R_WAIT;
            cnt   <= '0;
          end
        IBUS_R_WAIT:
          if (m_axi_rvalid || tmo) begin
            state <= m_axi_rvalid ? IBUS_IDLE : IBUS_DRAIN;
            cnt   <= '0;
          end else if (cnt != '1) cnt <= cnt + CW'(1);
        IBUS_DRAIN:
          if (m_axi_rvalid) state <= IBUS_IDLE;
        default: state <= IBUS_IDLE;
      endcase
    end
  assign m_axi_arvalid = state == IBUS_AR_SEND;
  assign m_axi_araddr  = {addr_q, 2'b00};
  assign m_axi_arprot  = ARPROT_VAL;
  assign m_axi_rready  = rwait || state == IBUS_DRAIN;
  assign o_ibus_rvalid = r_ok || tmo || pend;
  assign o_ibus_rdata  = pend ? hb_data : r_ok ? m_axi_rdata : '0;
  assign o_ibus_err    = r_ok ? m_axi_rresp != AXI_RESP_OKAY : tmo;
endmodule

// File: tb/tb_k10_ibus_axi.sv
// tb_k10_ibus_axi: randomized transaction-level check of k10_ibus_axi against a fetch/hit-buffer model.
module tb_k10_ibus_axi;
  localparam int TMO = 4;
`ifdef K10_IBUS_HITBUF_EN
  localparam bit HB = 1'b1;
`else
  localparam bit HB = 1'b0;
`endif
  logic        clk = 1'b0, rst, req, inv, arvalid, arready, rready, m_rvalid, gnt, rvalid, err;
  logic [31:0] addr, rdata, araddr, m_rdata;
  logic [2:0]  arprot;
  logic [1:0]  rresp;
  int          n_chk = 0, n_fail = 0;
  logic        hb_v = 1'b0;
  logic [29:0] hb_a = '0;
  logic [31:0] hb_d = '0;
  always #5 clk = ~clk;
  k10_ibus_axi #(.RESP_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_ibus_req(req), .i_ibus_addr(addr), .o_ibus_gnt(gnt),
    .o_ibus_rvalid(rvalid), .o_ibus_rdata(rdata), .o_ibus_err(err), .i_inv(inv),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_rvalid(m_rvalid), .m_axi_rready(rready), .m_axi_rdata(m_rdata), .m_axi_rresp(rresp)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // One fetch: slave accepts AR after ard cycles, answers after rd R-wait cycles.
  task automatic fetch(input logic [31:0] a, input int ard, input int rd, input logic [1:0] resp,
                       input logic [31:0] d, input logic iv);
    logic hit_e;
    hit_e = HB && hb_v && hb_a == a[31:2] && !iv;
    @(negedge clk);
    req = 1'b1; addr = a; inv = iv; arready = 1'b0; m_rvalid = 1'b0; #1;
    check("gnt", gnt, 1); check("arvalid_idle", arvalid, 0); check("rvalid_idle", rvalid, 0);
    if (iv) hb_v = 1'b0;
    if (hit_e) begin
      @(negedge clk);
      req = 1'($urandom_range(0, 1)); addr = $urandom; inv = 1'b0; #1;
      check("hit_rvalid", rvalid, 1); check("hit_rdata", rdata, hb_d); check("hit_err", err, 0);
      check("hit_gnt", gnt, 0); check("hit_arvalid", arvalid, 0);
      return;
    end
    for (int j = 0; j <= ard; j++) begin
      @(negedge clk);
      req = 1'($urandom_range(0, 1)); addr = $urandom; inv = 1'b0; arready = (j == ard); #1;
      check("arvalid", arvalid, 1); check("araddr", araddr, {a[31:2], 2'b00});
      check("ar_gnt", gnt, 0); check("ar_rvalid", rvalid, 0);
    end
    for (int i = 0; i <= rd; i++) begin
      @(negedge clk);
      arready = 1'b0; req = 1'($urandom_range(0, 1)); addr = $urandom;
      m_rvalid = (i == rd); m_rdata = (i == rd) ? d : $urandom; rresp = (i == rd) ? resp : 2'($urandom); #1;
      check("rready", rready, 1); check("r_gnt", gnt, 0);
      if (i == rd && i < TMO) begin
        check("rvalid", rvalid, 1); check("rdata", rdata, d); check("err", err, 32'(resp != 2'b00));
        if (resp == 2'b00) begin hb_v = 1'b1; hb_a = a[31:2]; hb_d = d; end
      end else if (i == TMO - 1) begin
        check("tmo_rvalid", rvalid, 1); check("tmo_err", err, 1); check("tmo_rdata", rdata, 0);
      end else check("no_rvalid", rvalid, 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] pool [4];
    rst = 1'b1; req = 1'b0; inv = 1'b0; addr = '0; arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; rresp = '0;
    #1;
    check("rst_gnt", gnt, 0); check("rst_arvalid", arvalid, 0); check("rst_rready", rready, 0);
    check("rst_rvalid", rvalid, 0); check("rst_rdata", rdata, 0); check("rst_err", err, 0);
    check("arprot", arprot, 3'b100);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fetch(32'h0000_1006, 0, 0, 2'b00, 32'hDEAD_BEEF, 1'b0);
    fetch(32'h0000_2000, 5, 3, 2'b00, 32'hCAFE_0001, 1'b0);
    fetch(32'h0000_0400, 0, 0, 2'b10, 32'h1234_5678, 1'b0);
    fetch(32'h0000_0400, 1, 1, 2'b00, 32'h0BAD_F00D, 1'b0);
    fetch(32'h0000_0500, 0, 10, 2'b00, 32'h5555_AAAA, 1'b0);
    fetch(32'h0000_0200, 0, 1, 2'b00, 32'h0000_0200, 1'b0);
    fetch(32'h0000_0202, 0, 1, 2'b00, 32'h0000_0200, 1'b0);
    @(negedge clk); req = 1'b0; inv = 1'b1; #1; check("inv_gnt", gnt, 0); hb_v = 1'b0;
    fetch(32'h0000_0200, 0, 0, 2'b00, 32'h0000_0201, 1'b0);
    fetch(32'h0000_0200, 0, 0, 2'b00, 32'h0000_0202, 1'b1);
    @(negedge clk); req = 1'b1; addr = 32'h300; inv = 1'b0; #1; check("mid_gnt", gnt, 1);
    @(negedge clk); req = 1'b0; arready = 1'b1; #1; check("mid_arvalid", arvalid, 1);
    @(negedge clk); arready = 1'b0; #1; check("mid_rready", rready, 1);
    #2 rst = 1'b1; #1;
    check("arst_arvalid", arvalid, 0); check("arst_rready", rready, 0); check("arst_rvalid", rvalid, 0);
    check("arst_gnt", gnt, 0); check("arst_rdata", rdata, 0); check("arst_err", err, 0);
    @(negedge clk); rst = 1'b0; hb_v = 1'b0;
    fetch(32'h0000_0100, 0, 0, 2'b00, 32'h0000_0100, 1'b0);
    pool[0] = 32'h200; pool[1] = 32'h204; pool[2] = 32'h100;
    for (int n = 0; n < 80; n++) begin
      pool[3] = $urandom & 32'hFFFF_FFFC;
      fetch(pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)), $urandom_range(0, 3),
            $urandom_range(0, 6), ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            $urandom, $urandom_range(0, 7) == 0);
    end
    @(negedge clk); req = 1'b0; m_rvalid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
